semaforo_sensor_req: RTL and testbench
======================================

Name: semaforo_sensor_req

Overview:
Input-side front end for the traffic-light controller. It converts raw push-button/switch inputs (car at street A, car at street B, emergency) into clean, latched sensor requests TA/TB/E. It holds each street request until the controller grants that street green, using the green-light outputs as the acknowledge. It sits between the board switches and the FSM sensor inputs and runs on the 100 MHz board clock.

Parameters:
DEB_CYCLES, 1_000_000, consecutive stable cycles required to accept a new input level (10 ms at 100 MHz); must be >= 2
STARVE_CYCLES, 500_000_000, pending cycles after which the starvation flag sets (5 s)
CNT_W, 32, width of debounce and wait counters; must hold max(DEB_CYCLES, STARVE_CYCLES)

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous active-low reset
btn_a  in  1  raw, asynchronous car sensor for street A
btn_b  in  1  raw, asynchronous car sensor for street B
btn_e  in  1  raw, asynchronous emergency switch
verde_a  in  1  green-light state for street A (grant/ack)
verde_b  in  1  green-light state for street B (grant/ack)
TA  out  1  street A request to controller
TB  out  1  street B request to controller
E  out  1  debounced emergency level
starve  out  2  [0]=A, [1]=B: request pending >= STARVE_CYCLES

Behaviour:
- Reset (async assert, sync release): all synchronizer flops, debounced levels, and counters = 0; both request FSMs = IDLE. TA=TB=E=0, starve=2'b00.
- Sync: each btn_* passes through a 2-flop synchronizer. The verde_* inputs are same-domain and are used directly.
- Debounce, per input: the counter increments while the synced input != the debounced level and resets to 0 when they are equal. When the counter reaches DEB_CYCLES-1 and the input still differs, the debounced level flips and the counter clears.
  - Latency from a clean edge to a debounced edge: 2 + DEB_CYCLES clocks.
  - A glitch shorter than DEB_CYCLES is fully rejected.
- Rise pulse: a one-cycle pulse when the debounced A (or B) level goes 0->1.
- Request FSM, one per street (X = A/B), states IDLE, PENDING, SERVED:
  - IDLE -> PENDING on rise_X when verde_X=0.
  - IDLE -> SERVED on rise_X when verde_X=1. The car passes on the current green, so no request is raised.
  - PENDING -> SERVED when verde_X=1 and E=0.
  - SERVED -> IDLE when verde_X=0.
  - Presses while in PENDING or SERVED are ignored (no queuing).
- Emergency: while E=1, PENDING is frozen. A green during an emergency does not count as service, so the request survives the emergency. New presses still move IDLE -> PENDING.
- Outputs: TA = (FSM_A == PENDING), registered; TB likewise. E = debounced emergency level.
- Wait counter, per street:
  - Clears on entry to PENDING and increments each cycle while PENDING.
  - Saturates at STARVE_CYCLES.
  - starve[X] = 1 when the counter equals STARVE_CYCLES and the FSM is in PENDING.
  - starve[X] clears in the cycle the FSM leaves PENDING.
- Simultaneous events:
  - A rise on both streets in the same cycle is handled independently.
  - Rise_X in the same cycle as the PENDING->SERVED transition has no effect.
- Reset mid-operation: all requests are dropped immediately. The sensor must be pressed again after release.

Decomposition:
- Package semaforo_pkg:
  - typedef enum logic [1:0] req_state_t {IDLE, PENDING, SERVED}
  - localparam defaults for DEB_CYCLES and STARVE_CYCLES
- Sub-module deb_sync (params DEB_CYCLES, CNT_W; ports clk, rst_n, din, level, rise): the 2-flop synchronizer plus debounce counter plus rise pulse. Instantiated three times.
- The request FSM and wait counter stay inline, generated per street.

Test Plan (bench uses DEB_CYCLES=4, STARVE_CYCLES=20):
1. Reset/idle: hold rst_n=0, toggle btn_a -> TA=TB=E=0 and starve=0 throughout. Release reset with btn_a=0 -> outputs remain 0.
2. Debounce: btn_a glitch high for 3 cycles -> TA stays 0. Then btn_a held high -> TA=1 exactly 2+4(+1 register) cycles after the edge.
3. Service handshake: TA=1, drive verde_a=1 -> TA=0 next cycle. Press btn_a again while verde_a=1 -> TA stays 0. Drop verde_a, then press -> TA=1.
4. Emergency hold: TB=1, btn_e high (E=1 after debounce), pulse verde_b=1 -> TB stays 1. Release btn_e (E=0), verde_b=1 -> TB=0.
5. Starvation: TA=1 with verde_a held 0 for 20 cycles -> starve[0]=1 at cycle 20 and stays 1. verde_a=1 -> starve[0]=0 and TA=0 on the same edge.
6. Concurrent/reset: press A and B in the same cycle -> TA=TB=1 together. Assert rst_n=0 asynchronously mid-PENDING -> TA=TB=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/semaforo_pkg.sv
// Shared types and default timing for the traffic-light sensor front end.
package semaforo_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SERVED  = 2'd2
  } req_state_t;

  localparam int DEB_CYCLES_DFLT    = 1_000_000;
  localparam int STARVE_CYCLES_DFLT = 500_000_000;
  localparam int CNT_W_DFLT         = 32;

endpackage

// File: rtl/semaforo_sensor_req_deb_sync.sv
// Two-flop synchronizer, debounce counter and rising-edge pulse for one raw switch.
module deb_sync
  import semaforo_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DFLT,
  parameter int CNT_W      = CNT_W_DFLT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;
  logic             flip;

  assign flip = (sync_q2 != level) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      level   <= 1'b0;
      rise    <= 1'b0;
      cnt     <= '0;
    end else begin
      sync_q1 <= din;
      sync_q2 <= sync_q1;
      // pulse lands in the same cycle the level first reads high
      rise    <= flip & sync_q2;
      if (sync_q2 == level) begin
        cnt <= '0;
      end else if (flip) begin
        level <= sync_q2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/semaforo_sensor_req.sv
// Sensor front end: debounced street requests held until the street turns green.
//   state   | meaning
//   IDLE    | no car waiting on this street
//   PENDING | car waiting, request raised to the controller
//   SERVED  | street is green for this car; wait for green to end
module semaforo_sensor_req
  import semaforo_pkg::*;
#(
  parameter int DEB_CYCLES    = DEB_CYCLES_DFLT,
  parameter int STARVE_CYCLES = STARVE_CYCLES_DFLT,
  parameter int CNT_W         = CNT_W_DFLT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_a,
  input  logic       btn_b,
  input  logic       btn_e,
  input  logic       verde_a,
  input  logic       verde_b,
  output logic       TA,
  output logic       TB,
  output logic       E,
  output logic [1:0] starve
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_CYCLES);

  // street levels only matter through their rising edge
  logic [1:0] lvl_unused;
  logic [1:0] rise;
  logic [1:0] verde;
  logic       e_lvl;
  logic       e_rise_unused;
  logic [1:0] req_q;
  logic [1:0] starve_q;

  assign verde = {verde_b, verde_a};

  deb_sync #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_a (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (btn_a),
    .level (lvl_unused[0]),
    .rise  (rise[0])
  );

  deb_sync #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_b (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (btn_b),
    .level (lvl_unused[1]),
    .rise  (rise[1])
  );

  deb_sync #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_e (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (btn_e),
    .level (e_lvl),
    .rise  (e_rise_unused)
  );

  for (genvar gi = 0; gi < 2; gi++) begin : g_street
    req_state_t       state;
    req_state_t       state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_nxt;
    logic             ta_q;
    logic             starve_bit_q;

    always_comb begin
      state_nxt = state;
      case (state)
        IDLE:    if (rise[gi]) state_nxt = verde[gi] ? SERVED : PENDING;
        // a green during an emergency is not service
        PENDING: if (verde[gi] && !e_lvl) state_nxt = SERVED;
        SERVED:  if (!verde[gi]) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase

      wait_nxt = wait_cnt;
      if (state_nxt == PENDING) begin
        if (state != PENDING)
          wait_nxt = '0;
        else if (wait_cnt != STARVE_LIM)
          wait_nxt = wait_cnt + CNT_W'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state        <= IDLE;
        wait_cnt     <= '0;
        ta_q         <= 1'b0;
        starve_bit_q <= 1'b0;
      end else begin
        state        <= state_nxt;
        wait_cnt     <= wait_nxt;
        ta_q         <= (state_nxt == PENDING);
        starve_bit_q <= (state_nxt == PENDING) && (wait_nxt == STARVE_LIM);
      end
    end

    assign req_q[gi]    = ta_q;
    assign starve_q[gi] = starve_bit_q;
  end

  assign TA     = req_q[0];
  assign TB     = req_q[1];
  assign E      = e_lvl;
  assign starve = starve_q;

endmodule

// File: tb/tb_semaforo_sensor_req.sv
// Table-driven, cycle-accurate bench for semaforo_sensor_req (DEB_CYCLES=4, STARVE_CYCLES=20).
module tb_semaforo_sensor_req;

  localparam int DEB    = 4;
  localparam int STARVE = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_a, btn_b, btn_e, verde_a, verde_b;
  logic       TA, TB, E;
  logic [1:0] starve;

  always #5 clk = ~clk;

  semaforo_sensor_req #(
    .DEB_CYCLES    (DEB),
    .STARVE_CYCLES (STARVE),
    .CNT_W         (32)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_a   (btn_a),
    .btn_b   (btn_b),
    .btn_e   (btn_e),
    .verde_a (verde_a),
    .verde_b (verde_b),
    .TA      (TA),
    .TB      (TB),
    .E       (E),
    .starve  (starve)
  );

  typedef struct packed {
    logic       ta;
    logic       tb;
    logic       e;
    logic [1:0] st;
  } exp_t;

  typedef struct {
    logic a, b, e, va, vb;
    int   n;
    exp_t x;
  } vec_t;

  vec_t tbl[$];
  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic exp_t outs();
    exp_t r;
    r = {TA, TB, E, starve};
    return r;
  endfunction

  task automatic check(input string name, input exp_t act, input exp_t req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got TA=%b TB=%b E=%b starve=%b, required TA=%b TB=%b E=%b starve=%b",
               name, act.ta, act.tb, act.e, act.st, req.ta, req.tb, req.e, req.st);
    end
  endtask

  // drive one cycle of inputs, queue the expectation, compare after the edge
  task automatic apply(input logic a, input logic b, input logic e, input logic va,
                       input logic vb, input exp_t x, input string name);
    btn_a   = a;
    btn_b   = b;
    btn_e   = e;
    verde_a = va;
    verde_b = vb;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      check(name, outs(), sb_q.pop_front());
    end
  endtask

  task automatic add(input logic a, input logic b, input logic e, input logic va,
                     input logic vb, input int n, input logic ta, input logic tb,
                     input logic ee, input logic [1:0] st);
    vec_t v;
    v.a = a; v.b = b; v.e = e; v.va = va; v.vb = vb; v.n = n;
    v.x.ta = ta; v.x.tb = tb; v.x.e = ee; v.x.st = st;
    tbl.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    //  a  b  e va vb   n  TA TB E  starve
    add(0, 0, 0, 0, 0,  3, 0, 0, 0, 2'b00);  // idle after reset
    add(1, 0, 0, 0, 0,  3, 0, 0, 0, 2'b00);  // 3-cycle glitch
    add(0, 0, 0, 0, 0,  4, 0, 0, 0, 2'b00);
    add(1, 0, 0, 0, 0,  6, 0, 0, 0, 2'b00);  // clean press, 2+DEB+1 latency
    add(1, 0, 0, 0, 0,  1, 1, 0, 0, 2'b00);
    add(1, 0, 0, 0, 0,  2, 1, 0, 0, 2'b00);
    add(1, 0, 0, 1, 0,  1, 0, 0, 0, 2'b00);  // green serves A
    add(0, 0, 0, 1, 0,  8, 0, 0, 0, 2'b00);
    add(0, 0, 0, 0, 0,  1, 0, 0, 0, 2'b00);
    add(1, 0, 0, 1, 0,  8, 0, 0, 0, 2'b00);  // press during green: no request
    add(1, 0, 0, 0, 0,  1, 0, 0, 0, 2'b00);
    add(0, 0, 0, 0, 0,  8, 0, 0, 0, 2'b00);
    add(1, 0, 0, 0, 0,  6, 0, 0, 0, 2'b00);  // press after green drops
    add(1, 0, 0, 0, 0,  1, 1, 0, 0, 2'b00);
    add(1, 0, 0, 0, 0, 19, 1, 0, 0, 2'b00);  // starvation build-up
    add(1, 0, 0, 0, 0,  1, 1, 0, 0, 2'b01);
    add(1, 0, 0, 0, 0,  3, 1, 0, 0, 2'b01);
    add(1, 0, 0, 1, 0,  1, 0, 0, 0, 2'b00);
    add(0, 0, 0, 0, 0,  8, 0, 0, 0, 2'b00);
    add(0, 1, 0, 0, 0,  6, 0, 0, 0, 2'b00);  // request B
    add(0, 1, 0, 0, 0,  1, 0, 1, 0, 2'b00);
    add(0, 1, 1, 0, 0,  5, 0, 1, 0, 2'b00);  // emergency on
    add(0, 1, 1, 0, 0,  1, 0, 1, 1, 2'b00);
    add(0, 1, 1, 0, 1,  2, 0, 1, 1, 2'b00);  // green during emergency
    add(0, 1, 1, 0, 0,  1, 0, 1, 1, 2'b00);
    add(0, 1, 0, 0, 0,  5, 0, 1, 1, 2'b00);  // emergency off
    add(0, 1, 0, 0, 0,  1, 0, 1, 0, 2'b00);
    add(0, 1, 0, 0, 1,  1, 0, 0, 0, 2'b00);  // B served
    add(0, 0, 0, 0, 0,  1, 0, 0, 0, 2'b00);
    add(0, 0, 0, 0, 0,  7, 0, 0, 0, 2'b00);
    add(1, 1, 0, 0, 0,  6, 0, 0, 0, 2'b00);  // simultaneous A and B
    add(1, 1, 0, 0, 0,  1, 1, 1, 0, 2'b00);
    add(1, 1, 0, 0, 0,  2, 1, 1, 0, 2'b00);

    rst_n   = 1'b0;
    btn_a   = 1'b0;
    btn_b   = 1'b0;
    btn_e   = 1'b0;
    verde_a = 1'b0;
    verde_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++)
      apply(logic'(i % 2 == 0), 1'b0, 1'b0, 1'b0, 1'b0, exp_t'(5'b0),
            $sformatf("in_reset_%0d", i));
    rst_n = 1'b1;

    for (int r = 0; r < tbl.size(); r++)
      for (int k = 0; k < tbl[r].n; k++)
        apply(tbl[r].a, tbl[r].b, tbl[r].e, tbl[r].va, tbl[r].vb, tbl[r].x,
              $sformatf("vec%0d_%0d", r, k));

    // reset mid-PENDING must drop both requests without a clock edge
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_reset", outs(), exp_t'(5'b0));
    btn_a = 1'b0;
    btn_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++)
      apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_t'(5'b0), $sformatf("post_reset_%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
